// File: rtl/fixed_pkg.sv
// Shared Qm.n definitions for the perceptron fixed-point datapath: default
// format, derived width, multiplier FSM states and range limits.
package fixed_pkg;

    localparam int Q_M_DEF = 17;
    localparam int Q_N_DEF = 16;
    localparam int W_DEF   = Q_M_DEF + Q_N_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } mul_state_t;

    // Largest positive / most negative raw value of the default Qm.n format.
    localparam logic [W_DEF-1:0] QMAX_DEF = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] QMIN_DEF = {1'b1, {(W_DEF-1){1'b0}}};

endpackage

// File: rtl/fixed_multiplier_seq.sv
// Sequential signed Qm.n shift-add multiplier, one multiplier bit per cycle.
// Define FIXED_MUL_SATURATE_EN to clamp overflowing products instead of wrapping.
module fixed_multiplier_seq
    import fixed_pkg::*;
#(
    parameter int q_m = Q_M_DEF,
    parameter int q_n = Q_N_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [q_m+q_n-1:0]   a_in,
    input  logic [q_m+q_n-1:0]   b_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [q_m+q_n-1:0]   y_out,
    output logic                 overflow_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    localparam int W    = q_m + q_n;
    localparam int CW   = $clog2(W);
    localparam int AW   = 2 * W;

    localparam logic [W-1:0]  Y_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  Y_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [AW-1:0] LIM_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [AW-1:0] LIM_NEG = {{(W){1'b0}}, 1'b1, {(W-1){1'b0}}};

    mul_state_t      state_q, state_d;
    logic [W-1:0]    a_mag_q, a_mag_d;
    logic [W-1:0]    b_mag_q, b_mag_d;
    logic            sign_q, sign_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic            ovf_q, ovf_d;

    logic [AW-1:0]   mag;
    logic [W-1:0]    wrap_val;
    logic            ovf_now;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    // Magnitude of the scaled product truncates, so applying the sign
    // afterwards rounds toward zero; -0 collapses to 0 in two's complement.
    always_comb begin
        mag      = acc_q >> q_n;
        wrap_val = sign_q ? (~mag[W-1:0] + 1'b1) : mag[W-1:0];
        ovf_now  = sign_q ? (mag > LIM_NEG) : (mag > LIM_POS);
    end

    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    a_mag_d = a_in[W-1] ? (~a_in + 1'b1) : a_in;
                    b_mag_d = b_in[W-1] ? (~b_in + 1'b1) : b_in;
                    sign_d  = a_in[W-1] ^ b_in[W-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (b_mag_q[cnt_q])
                    acc_d = acc_q + ({{W{1'b0}}, a_mag_q} << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1))
                    state_d = FINISH;
            end
            FINISH: begin
                ovf_d = ovf_now;
`ifdef FIXED_MUL_SATURATE_EN
                if (ovf_now)
                    y_d = sign_q ? Y_MIN : Y_MAX;
                else
                    y_d = wrap_val;
`else
                y_d = wrap_val;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (ready_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_out    = (state_q == IDLE) && rst_ni;
    assign valid_out    = (state_q == DONE);
    assign y_out        = y_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_fixed_multiplier_seq.sv
// Directed bench for fixed_multiplier_seq with a queue-based scoreboard.
module tb_fixed_multiplier_seq;

    localparam int W = 33;

    typedef struct packed {
        logic [W-1:0] y;
        logic         ovf;
    } res_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [W-1:0] a_in, b_in;
    logic         valid_in, ready_out, overflow_out, valid_out, ready_in;
    logic [W-1:0] y_out;

    int total  = 0;
    int passed = 0;
    res_t sb[$];

    fixed_multiplier_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .a_in(a_in), .b_in(b_in),
        .valid_in(valid_in), .ready_out(ready_out), .y_out(y_out),
        .overflow_out(overflow_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Reference: exact signed product, scaled by 2^-16 rounding toward zero.
    function automatic res_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p, s;
        logic signed [2*W-1:0] maxv, minv;
        res_t r;
        maxv = 66'sd4294967295;
        minv = -66'sd4294967296;
        p = a * b;
        s = (p < 0) ? -((-p) >>> 16) : (p >>> 16);
        r.ovf = (s > maxv) || (s < minv);
`ifdef FIXED_MUL_SATURATE_EN
        if (r.ovf) r.y = (s < 0) ? minv[W-1:0] : maxv[W-1:0];
        else       r.y = s[W-1:0];
`else
        r.y = s[W-1:0];
`endif
        return r;
    endfunction

    // Issue one operation, wait for its result and score it.
    task automatic do_op(input string tag, input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b, input int hold);
        int n;
        res_t e;
        logic [W-1:0] held;
        n = 0;
        while (!ready_out && n < 100) begin @(negedge clk_i); n++; end
        chk({tag, "_rdy"}, 64'(ready_out), 64'd1);
        sb.push_back(model(a, b));
        a_in = a; b_in = b; valid_in = 1'b1; ready_in = (hold == 0);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_in = 1'b0;
        a_in = $urandom; b_in = $urandom;
        n = 0;
        while (!valid_out && n < 100) begin @(negedge clk_i); n++; end
        chk({tag, "_lat"}, 64'(n), 64'd34);
        e = sb.pop_front();
        chk({tag, "_y"}, 64'(y_out), 64'(e.y));
        chk({tag, "_ovf"}, 64'(overflow_out), 64'(e.ovf));
        if (hold > 0) begin
            held = y_out;
            for (int i = 0; i < hold; i++) begin
                a_in = 33'd777; b_in = 33'd555; valid_in = 1'b1;
                @(negedge clk_i);
                chk({tag, "_bp_vld"}, 64'(valid_out), 64'd1);
                chk({tag, "_bp_y"}, 64'(y_out), 64'(held));
                chk({tag, "_bp_rdy"}, 64'(ready_out), 64'd0);
            end
            valid_in = 1'b0;
            ready_in = 1'b1;
        end
        @(negedge clk_i);
        chk({tag, "_vld_drop"}, 64'(valid_out), 64'd0);
        chk({tag, "_idle"}, 64'(ready_out), 64'd1);
    endtask

    initial begin
        int n;
        rst_ni = 1'b0; valid_in = 1'b0; ready_in = 1'b1; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_rdy", 64'(ready_out), 64'd0);
        chk("rst_vld", 64'(valid_out), 64'd0);
        chk("rst_y", 64'(y_out), 64'd0);
        chk("rst_ovf", 64'(overflow_out), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_rdy", 64'(ready_out), 64'd1);

        do_op("t1", 33'sd98304, 33'sd131072, 0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        do_op("t2a", -33'sd98304, 33'sd131072, 0);
        do_op("t2b", 33'sd0, -33'sd146, 0);
        do_op("t3a", 33'sd1, 33'sd1, 0);
        do_op("t3b", -33'sd1, 33'sd1, 0);
        do_op("t4", 33'sd19660800, 33'sd19660800, 0);
        do_op("minpos", -33'sd4294967296, 33'sd65536, 0);
        do_op("minneg", -33'sd4294967296, -33'sd65536, 0);
        do_op("t5_bp", 33'sd327680, -33'sd65536, 5);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Abort an operation with a one-edge reset partway through BUSY.
        a_in = 33'sd500000; b_in = 33'sd700000; valid_in = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_in = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("t6_rst_rdy", 64'(ready_out), 64'd0);
        chk("t6_rst_vld", 64'(valid_out), 64'd0);
        rst_ni = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_out) n++;
        end
        chk("t6_no_result", 64'(n), 64'd0);
        chk("t6_idle", 64'(ready_out), 64'd1);
        do_op("t6_next", 33'sd123, 33'sd146, 0);

        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ra, rb;
            ra = {$urandom_range(0, 1) == 1, 32'($urandom)};
            rb = {$urandom_range(0, 1) == 1, 16'h0, 16'($urandom)};
            do_op($sformatf("rnd%0d", i), ra, rb, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
